// File: rtl/tape_reader_if.sv
// Bus between the tape reader and its surroundings: scan control in,
// tape address and read-out results back.
interface tape_reader_if;
   logic       start;
   logic       mode;
   logic       step;
   logic [1:0] read_data;
   logic [2:0] head;
   logic       busy;
   logic       done;
   logic       error;
   logic [7:0] value;
   logic [3:0] length;
   logic [7:0] led;

   modport master (
      output start, mode, step, read_data,
      input  head, busy, done, error, value, length, led
   );

   modport slave (
      input  start, mode, step, read_data,
      output head, busy, done, error, value, length, led
   );
endinterface

// File: rtl/tape_reader.sv
// Tape reader: scans the tape from cell 0 upward, assembling the binary
// value it holds (LSB at cell 0) until a blank, an illegal symbol, or the
// last cell. Auto mode consumes one cell per cycle; step mode consumes one
// cell per rising edge of the debounced step button.
module tape_reader #(
   parameter int CELLS = 8
) (
   input logic          clk,
   input logic          rst,
   tape_reader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_ONE  = 2'b01;
   localparam logic [1:0] SYM_B    = 2'b10;
   localparam logic [2:0] LAST     = 3'(CELLS - 1);

   state_t     state, state_n;
   logic [2:0] head, head_n;
   logic [7:0] value, value_n;
   logic [3:0] length, length_n;
   logic       error, error_n;
   logic       mode_q, mode_n;
   logic       step_q;
   logic       step_edge_q;
   logic       consume;

   // Step button edge detect; an edge only matters while scanning in step
   // mode, so edges seen elsewhere are dropped rather than queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q      <= 1'b0;
         step_edge_q <= 1'b0;
      end else begin
         step_q      <= bus.step;
         step_edge_q <= bus.step & ~step_q & (state == SCAN) & mode_q;
      end
   end

   assign consume = (state == SCAN) && (!mode_q || step_edge_q);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         head   <= 3'd0;
         value  <= 8'd0;
         length <= 4'd0;
         error  <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         state  <= state_n;
         head   <= head_n;
         value  <= value_n;
         length <= length_n;
         error  <= error_n;
         mode_q <= mode_n;
      end
   end

   // Next-state and datapath update: start (re)arms a scan, each consume
   // cycle acts on the symbol under the head.
   always_comb begin
      state_n  = state;
      head_n   = head;
      value_n  = value;
      length_n = length;
      error_n  = error;
      mode_n   = mode_q;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n  = SCAN;
               head_n   = 3'd0;
               value_n  = 8'd0;
               length_n = 4'd0;
               error_n  = 1'b0;
               mode_n   = bus.mode;
            end
         end
         SCAN: begin
            if (consume) begin
               case (bus.read_data)
                  SYM_ZERO, SYM_ONE: begin
                     value_n[head] = bus.read_data[0];
                     length_n      = length + 4'd1;
                     // Last cell ends the scan without wrapping the head.
                     if (head == LAST) begin
                        state_n = DONE;
                        head_n  = 3'd0;
                     end else begin
                        head_n = head + 3'd1;
                     end
                  end
                  SYM_B: begin
                     state_n = DONE;
                     head_n  = 3'd0;
                  end
                  default: begin
                     error_n = 1'b1;
                     state_n = DONE;
                     head_n  = 3'd0;
                  end
               endcase
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.head   = head;
   assign bus.busy   = (state == SCAN);
   assign bus.done   = (state == DONE);
   assign bus.error  = error;
   assign bus.value  = value;
   assign bus.length = length;
   assign bus.led    = value;

endmodule

// File: tb/tb_tape_reader.sv
// Self-checking bench for tape_reader: directed scenarios plus random tapes,
// checked against a cell-by-cell reference model of the scan rules.
module tb_tape_reader;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [1:0] tape [8];

   tape_reader_if bus();

   tape_reader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.read_data = tape[bus.head];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Cell i of the tape sits in bits [2i+1:2i].
   task automatic set_tape(input logic [15:0] cells);
      for (int i = 0; i < 8; i++) tape[i] = cells[2*i +: 2];
   endtask

   // Reference: walk the tape until a blank, an illegal symbol or the end.
   // cyc is the number of edges after start until done rises.
   task automatic model(output logic [7:0] v, output int len, output bit err, output int cyc);
      v = 8'd0; len = 0; err = 1'b0; cyc = 8;
      for (int i = 0; i < 8; i++) begin
         if (tape[i] == 2'b10) begin cyc = i + 1; break; end
         if (tape[i] == 2'b11) begin err = 1'b1; cyc = i + 1; break; end
         v[i] = tape[i][0];
         len++;
      end
   endtask

   // Auto scan of the current tape; mid_start > 0 pulses start on that edge.
   task automatic run_auto(input string tag, input int mid_start);
      logic [7:0] ev;
      int         el, ec, n;
      bit         ee, overlap;
      model(ev, el, ee, ec);
      @(negedge clk);
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, ".busy0"}, bus.busy, 1);
      check({tag, ".done0"}, bus.done, 0);
      overlap = 0;
      for (n = 1; n <= 30; n++) begin
         bus.start = (n == mid_start);
         @(posedge clk); #1;
         if (bus.busy && bus.done) overlap = 1;
         if (bus.done) break;
      end
      bus.start = 1'b0;
      check({tag, ".cycles"}, n, ec);
      check({tag, ".value"}, bus.value, ev);
      check({tag, ".length"}, bus.length, el);
      check({tag, ".error"}, bus.error, ee);
      check({tag, ".led"}, bus.led, ev);
      check({tag, ".head"}, bus.head, 0);
      check({tag, ".busy"}, bus.busy, 0);
      check({tag, ".overlap"}, overlap, 0);
   endtask

   initial begin
      bit ok;
      total = 0; bad = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = 1'b0; bus.step = 1'b0;
      set_tape(16'hAAAA);
      repeat (2) @(posedge clk);
      #1;
      check("rst.head", bus.head, 0);
      check("rst.busy", bus.busy, 0);
      check("rst.done", bus.done, 0);
      check("rst.error", bus.error, 0);
      check("rst.value", bus.value, 0);
      check("rst.length", bus.length, 0);
      check("rst.led", bus.led, 0);
      rst = 1'b0;

      // 1,0,1,1,B
      set_tape(16'hAA51);
      run_auto("term", 0);
      check("term.val_k", bus.value, 8'h0D);
      check("term.len_k", bus.length, 4);

      // all ONE, no terminator
      set_tape(16'h5555);
      run_auto("full", 0);
      check("full.val_k", bus.value, 8'hFF);
      check("full.len_k", bus.length, 8);

      // B at cell 0
      set_tape(16'hAAAA);
      run_auto("empty", 0);
      check("empty.len_k", bus.length, 0);

      // 1,1,illegal
      set_tape(16'hAAB5);
      run_auto("illegal", 0);
      check("illegal.err_k", bus.error, 1);
      check("illegal.val_k", bus.value, 8'h03);
      check("illegal.len_k", bus.length, 2);

      // step mode: 0,1,B
      set_tape(16'hAAA4);
      @(negedge clk);
      bus.mode = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mode = 1'b0;
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!(bus.busy === 1'b1 && bus.head === 3'd0)) ok = 0;
      end
      check("step.idle_hold", ok, 1);
      for (int k = 0; k < 3; k++) begin
         bus.step = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         check("step.head", bus.head, (k == 2) ? 0 : k + 1);
         check("step.done", bus.done, (k == 2));
         bus.step = 1'b0;
         repeat (2) @(posedge clk);
         #1;
      end
      check("step.value", bus.value, 8'h02);
      check("step.length", bus.length, 2);
      check("step.error", bus.error, 0);

      // reset on the 3rd edge of an auto scan
      set_tape(16'h5555);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst.busy", bus.busy, 0);
      check("midrst.done", bus.done, 0);
      check("midrst.head", bus.head, 0);
      check("midrst.value", bus.value, 0);
      check("midrst.length", bus.length, 0);
      check("midrst.led", bus.led, 0);
      set_tape(16'hAA51);
      run_auto("after_rst", 0);
      check("after_rst.val_k", bus.value, 8'h0D);

      // start during SCAN is ignored
      set_tape(16'h5555);
      run_auto("ign_start", 3);

      // restart from DONE after the tape changes to 1,1,1,B
      set_tape(16'hAA95);
      run_auto("restart", 0);
      check("restart.val_k", bus.value, 8'h07);

      // random tapes
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 8; i++) begin
            int x;
            x = $urandom_range(0, 11);
            tape[i] = (x < 5) ? 2'b00 : (x < 10) ? 2'b01 : (x == 10) ? 2'b10 : 2'b11;
         end
         run_auto("rand", 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tape_reader.md
# tape_reader

Scans an 8-cell, 2-bit-symbol tape from head 0 upward and assembles the binary value it holds, LSB at cell 0. It is the read-out end of the tape datapath: the adder FSM writes the SUM tape, and this block reads that tape back and drives the LED bank. It can also dump either input tape. It owns the head address of the tape it reads. The tape is read combinationally, so `read_data` reflects `head` in the same cycle.

## Interface
- Parameters:
- `CELLS`, default 8: number of tape cells; `head` width is 3 and is fixed for 8.
- Symbol encoding is fixed: ZERO = 2'b00, ONE = 2'b01, B (blank) = 2'b10; 2'b11 is illegal.
- Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE or DONE.
- `mode`  in  1  0 = auto scan (one cell per cycle); 1 = step scan (one cell per `step` rising edge); sampled at start.
- `step`  in  1  debounced button level; rising edge detected internally.
- `read_data`  in  2  symbol at `head`, combinational from tape.
- `head`  out  3  tape address.
- `busy`  out  1  high in SCAN.
- `done`  out  1  high in DONE, held until the next start or reset.
- `error`  out  1  illegal symbol seen in the last scan; valid while `done`.
- `value`  out  8  assembled bits; bit i = cell i.
- `length`  out  4  digits read before the terminator (0..8).
- `led`  out  8  equals `value`.

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE:** all outputs 0. On `start`, go to SCAN with these actions:
  - clear `value`, `length` and `error`;
  - set `head` = 0;
  - latch `mode` into `mode_q`.
- **SCAN:** a cell is consumed on every cycle when `mode_q`=0, or on a `step` rising edge when `mode_q`=1. On a consume cycle, act on `read_data`:
  - **ZERO / ONE:** write `value[head]` = `read_data[0]` and increment `length`.
    - If `head` < 7, increment `head`.
    - If `head` = 7, go to DONE. `head` does not wrap; all 8 cells are read and `length` = 8.
  - **B:** go to DONE. `value` and `length` are unchanged.
  - **2'b11:** set `error` = 1 and go to DONE. Bits read so far are kept.
- **DONE:** `head` = 0 and `done` = 1.
  - `value`, `length` and `error` hold.
  - `start` re-enters SCAN with the same actions as from IDLE.
- `start` during SCAN is ignored.
- `step` edges outside SCAN, or in SCAN with `mode_q`=0, are ignored.
- Step edge detect: `step_q` is a register holding the previous `step`, reset to 0. An edge is `step & ~step_q`. If `step` is high when reset releases, that counts as one edge.
- **Reset:** `rst` mid-scan returns to IDLE in the next cycle.
  - All outputs go to 0, `step_q` to 0 and `mode_q` to 0.
  - The tape is untouched.
- Cells above the terminator are never read. A B at cell 0 gives `value`=0 and `length`=0 with no error.

## Timing
- Auto mode: `start` is seen at edge 0, and cell i is consumed at edge i+1.
  - With N digits plus a terminator (N<8), DONE is entered at edge N+1.
  - With 8 digits and no terminator, DONE is entered at edge 8.
- Step mode: one cell per step edge.
  - An edge is registered the cycle after `step` rises.
  - The cell is consumed on the edge after that.
- `value`, `length` and `led` update one cycle after the consume cycle, and become final in the same cycle that `done` rises.
- `busy` and `done` are never both high. `head` changes only on consume cycles, on entry to SCAN, or on entry to DONE.

## Test plan
- **Auto scan, terminated:** tape = 1,0,1,1,B,… and `start` with `mode`=0.
  - Required: `done` at the 5th edge after start.
  - `value`=8'h0D, `length`=4, `error`=0, `led`=8'h0D, `head`=0.
- **Full tape:** all 8 cells ONE, auto scan.
  - Required: `done` after 8 edges with `value`=8'hFF and `length`=8.
  - `head` never exceeds 7 and does not wrap.
- **Empty tape and illegal symbol:**
  - Cell 0 = B → `value`=0, `length`=0, `error`=0.
  - Tape 1,1,2'b11 → `error`=1, `value`=8'h03, `length`=2.
- **Step mode:** tape 0,1,B with `mode`=1 and `step` held low for 20 cycles.
  - Required: `busy`=1 and `head`=0 throughout.
  - Three rising edges of `step` → DONE with `value`=8'h02. Held-high `step` between edges causes no extra advance.
- **Reset mid-scan:** assert `rst` on the 3rd edge of an auto scan.
  - Required: the next cycle shows IDLE with all outputs 0.
  - A subsequent `start` re-reads from cell 0 correctly.
- **Restart and ignored start:**
  - `start` pulsed during SCAN → no effect.
  - `start` in DONE after the tape changes to 1,1,1,B → `done` drops, then returns with `value`=8'h07.
